// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped down-counter timer that raises a level interrupt on expiry.
module timer_irq_source #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        writeEnable,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, CNT, INT} state_t;
  state_t state;
  logic en, im, pending;
  logic [1:0] mode;
  logic [COUNT_WIDTH-1:0] preset, count;
  logic ctrlWr;
  assign ctrlWr = writeEnable && addr == 2'd0;
  assign irq = pending & im;
  assign readData = addr == 2'd0 ? {28'd0, im, mode, en} :
                    addr == 2'd1 ? 32'(preset) :
                    addr == 2'd2 ? 32'(count) : 32'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      en      <= 1'b0;
      im      <= 1'b0;
      mode    <= 2'd0;
      pending <= 1'b0;
      preset  <= '0;
      count   <= '0;
    end else begin
      if (ctrlWr) pending <= 1'b0;
      case (state)
        IDLE: if (en) begin
          count <= preset;
          state <= CNT;
        end
        CNT: if (!en) state <= IDLE;
          else if (count > COUNT_WIDTH'(1)) count <= count - COUNT_WIDTH'(1);
          else begin
            count   <= '0;
            pending <= 1'b1;
            state   <= INT;
          end
        INT: if (mode != 2'b01) begin
          en    <= 1'b0;
          state <= IDLE;
        end else if (!en) state <= IDLE;
          else begin
            count <= preset;
            state <= CNT;
          end
        default: state <= IDLE;
      endcase
      // a CPU CTRL write overrides the one-shot auto-disable on the same edge
      if (ctrlWr) begin
        en   <= writeData[0];
        mode <= writeData[2:1];
        im   <= writeData[3];
      end
      if (writeEnable && addr == 2'd1) preset <= writeData[COUNT_WIDTH-1:0];
    end
  end
endmodule
